// File: rtl/bus_xfer_seq.sv
// Single-bus transfer sequencer: immediate or register-to-register moves over a shared 8-bit bus.
// done is high SETTLE+2 cycles after acceptance; req_ready is held low until the FSM is back in IDLE.
module bus_xfer_seq #(
  parameter int NREG   = 4,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_imm,
  input  logic [2:0]      req_src,
  input  logic [2:0]      req_dst,
  input  logic [7:0]      req_data,
  input  logic [7:0]      bus_in,
  output logic [7:0]      bus_out,
  output logic            bus_oe,
  output logic [NREG-1:0] oa,
  output logic [NREG-1:0] wa,
  output logic            done,
  output logic            err,
  output logic [7:0]      xfer_data,
  output logic [7:0]      xfer_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    LATCH = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  typedef struct packed {
    logic       imm;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] data;
  } req_t;

  state_t         state, state_nxt;
  logic [3:0]     settle_cnt, settle_cnt_nxt;
  req_t           cur;
  logic           accept;
  logic           req_bad;
  logic           src_oob, dst_oob;
  logic           drive_phase;
  logic [NREG-1:0] src_sel, dst_sel;

  assign accept  = req_valid && req_ready;
  assign dst_oob = ({1'b0, req_dst} >= 4'(NREG));
  assign src_oob = ({1'b0, req_src} >= 4'(NREG));
  assign req_bad = dst_oob || (!req_imm && (src_oob || (req_src == req_dst)));

  assign src_sel = NREG'(1) << cur.src;
  assign dst_sel = NREG'(1) << cur.dst;

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      xfer_data  <= 8'h00;
      xfer_count <= 8'h00;
      cur        <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      if (accept) begin
        cur <= '{imm: req_imm, src: req_src, dst: req_dst, data: req_data};
      end
      if (state == LATCH) begin
        xfer_data  <= bus_in;
        xfer_count <= xfer_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    req_ready      = 1'b0;
    drive_phase    = 1'b0;
    oa             = '0;
    wa             = '0;
    bus_oe         = 1'b0;
    bus_out        = 8'h00;
    done           = 1'b0;
    err            = 1'b0;

    case (state)
      IDLE: begin
        req_ready = !clr;
        if (accept) begin
          if (req_bad) begin
            state_nxt = ERR;
          end else if (SETTLE > 0) begin
            state_nxt      = DRIVE;
            settle_cnt_nxt = 4'(SETTLE);
          end else begin
            state_nxt = LATCH;
          end
        end
      end
      DRIVE: begin
        drive_phase = 1'b1;
        // Counter holds the number of DRIVE cycles still to go, including this one.
        if (settle_cnt <= 4'd1) begin
          state_nxt      = LATCH;
          settle_cnt_nxt = 4'd0;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      LATCH: begin
        drive_phase = 1'b1;
        wa          = clr ? '0 : dst_sel;
        state_nxt   = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Bus drivers are killed combinationally by clr so the reset cycle never writes a register.
    if (drive_phase && !clr) begin
      if (cur.imm) begin
        bus_oe  = 1'b1;
        bus_out = cur.data;
      end else begin
        oa = src_sel;
      end
    end
  end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Bench for bus_xfer_seq: shared-bus register file environment plus a transaction-level reference model.
module tb_bus_xfer_seq;

  localparam int NREG   = 4;
  localparam int SETTLE = 1;

  logic            clk = 1'b0;
  logic            clr;
  logic            req_valid;
  logic            req_ready;
  logic            req_imm;
  logic [2:0]      req_src;
  logic [2:0]      req_dst;
  logic [7:0]      req_data;
  logic [7:0]      bus_in;
  logic [7:0]      bus_out;
  logic            bus_oe;
  logic [NREG-1:0] oa;
  logic [NREG-1:0] wa;
  logic            done;
  logic            err;
  logic [7:0]      xfer_data;
  logic [7:0]      xfer_count;

  bus_xfer_seq #(.NREG(NREG), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_imm    (req_imm),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .req_data   (req_data),
    .bus_in     (bus_in),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .oa         (oa),
    .wa         (wa),
    .done       (done),
    .err        (err),
    .xfer_data  (xfer_data),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc  = 0;
  int prev_acc = -1;
  bit mon_on = 1'b0;

  // Physical register file sitting on the bus; undriven bus floats to 8'hFF.
  logic [7:0] regs     [8] = '{8'h11, 8'h3C, 8'h22, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  // Reference model state, updated per transaction from the request rules alone.
  logic [7:0] ref_regs [8] = '{8'h11, 8'h3C, 8'h22, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] ref_cnt  = 8'h00;
  logic [7:0] ref_data = 8'h00;

  function automatic logic [2:0] oh_idx(input logic [NREG-1:0] v);
    oh_idx = 3'd0;
    for (int i = 0; i < NREG; i++) if (v[i]) oh_idx = 3'(i);
  endfunction

  assign bus_in = bus_oe ? bus_out : ((oa != '0) ? regs[oh_idx(oa)] : 8'hFF);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wa != '0) regs[oh_idx(wa)] <= bus_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("oa_onehot", 32'($countones(oa) <= 1), 32'd1);
      chk("wa_onehot", 32'($countones(wa) <= 1), 32'd1);
      chk("oa_vs_oe", 32'((oa != '0) && bus_oe), 32'd0);
      chk("bus_out_idle", 32'(bus_oe || (bus_out == 8'h00)), 32'd1);
    end
  end

  task automatic accept_req(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                            input logic [7:0] data, input bit hold, output bit ok);
    int w;
    w  = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_imm   = imm;
    req_src   = src;
    req_dst   = dst;
    req_data  = data;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = hold;
    // Scramble the request lines: the captured request must not follow them.
    req_imm   = 1'($urandom);
    req_src   = 3'($urandom);
    req_dst   = 3'($urandom);
    req_data  = 8'($urandom);
    ok = 1'b1;
  endtask

  task automatic xfer(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                      input logic [7:0] data, input bit hold);
    bit ok;
    bit bad;
    logic [7:0] val;
    logic [NREG-1:0] one;
    logic [NREG-1:0] e_oa, e_wa;
    bit drv;
    one = 1;
    bad = (dst >= NREG) || (!imm && ((src >= NREG) || (src == dst)));
    val = imm ? data : ref_regs[src];
    accept_req(imm, src, dst, data, hold, ok);
    if (!ok) return;
    if (hold && prev_acc >= 0) chk("spacing", 32'(acc_cyc - prev_acc), 32'(SETTLE + 3));
    prev_acc = acc_cyc;
    if (bad) begin
      @(negedge clk);
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_done", 32'(done), 32'd0);
      chk("rej_oa", 32'(oa), 32'd0);
      chk("rej_wa", 32'(wa), 32'd0);
      chk("rej_oe", 32'(bus_oe), 32'd0);
    end else begin
      ref_regs[dst] = val;
      ref_cnt       = ref_cnt + 8'd1;
      ref_data      = val;
      for (int k = 1; k <= SETTLE + 2; k++) begin
        @(negedge clk);
        drv  = (k <= SETTLE + 1);
        e_oa = (drv && !imm) ? (one << src) : '0;
        e_wa = (k == SETTLE + 1) ? (one << dst) : '0;
        chk($sformatf("oa_k%0d", k), 32'(oa), 32'(e_oa));
        chk($sformatf("wa_k%0d", k), 32'(wa), 32'(e_wa));
        chk($sformatf("oe_k%0d", k), 32'(bus_oe), 32'(drv && imm));
        chk($sformatf("bus_out_k%0d", k), 32'(bus_out), 32'((drv && imm) ? data : 8'h00));
        chk($sformatf("done_k%0d", k), 32'(done), 32'(k == SETTLE + 2));
        chk($sformatf("err_k%0d", k), 32'(err), 32'd0);
      end
      chk("regfile", 32'(regs[dst]), 32'(val));
    end
    chk("xfer_data", 32'(xfer_data), 32'(ref_data));
    chk("xfer_count", 32'(xfer_count), 32'(ref_cnt));
  endtask

  initial begin
    bit ok;
    clr       = 1'b1;
    req_valid = 1'b0;
    req_imm   = 1'b0;
    req_src   = 3'd0;
    req_dst   = 3'd0;
    req_data  = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_oa", 32'(oa), 32'd0);
    chk("rst_wa", 32'(wa), 32'd0);
    chk("rst_oe", 32'(bus_oe), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    chk("rst_xfer_data", 32'(xfer_data), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_ready_in_clr", 32'(req_ready), 32'd0);
    clr = 1'b0;
    #1;
    chk("rst_ready_after", 32'(req_ready), 32'd1);
    mon_on = 1'b1;

    // Immediate load, then register move, then the two reject cases
    xfer(1'b1, 3'd0, 3'd2, 8'hA5, 1'b0);
    chk("first_count", 32'(xfer_count), 32'd1);
    xfer(1'b0, 3'd1, 3'd3, 8'h00, 1'b0);
    chk("move_data", 32'(xfer_data), 32'h3C);
    xfer(1'b0, 3'd2, 3'd2, 8'h99, 1'b0);
    xfer(1'b1, 3'd0, 3'd5, 8'h99, 1'b0);

    // Random mix of good and bad requests
    for (int i = 0; i < 40; i++) begin
      xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)),
           8'($urandom), 1'b0);
    end

    // Abort during LATCH
    accept_req(1'b1, 3'd0, 3'd2, 8'h5A, 1'b0, ok);
    if (ok) begin
      for (int k = 1; k <= SETTLE + 1; k++) @(negedge clk);
      chk("abort_wa_before", 32'(wa), 32'b0100);
      clr = 1'b1;
      #1;
      chk("abort_wa", 32'(wa), 32'd0);
      chk("abort_oe", 32'(bus_oe), 32'd0);
      chk("abort_oa", 32'(oa), 32'd0);
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_count", 32'(xfer_count), 32'd0);
      chk("abort_data", 32'(xfer_data), 32'd0);
      chk("abort_ready_in_clr", 32'(req_ready), 32'd0);
      chk("abort_reg_kept", 32'(regs[2]), 32'(ref_regs[2]));
      clr = 1'b0;
      #1;
      chk("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      ref_cnt  = 8'h00;
      ref_data = 8'h00;
    end

    // 256 back-to-back immediate transfers with req_valid held high
    prev_acc = -1;
    for (int i = 0; i < 256; i++) begin
      xfer(1'b1, 3'd0, 3'($urandom_range(0, NREG - 1)), 8'($urandom), 1'b1);
    end
    req_valid = 1'b0;
    chk("wrap_count", 32'(xfer_count), 32'h00);

    @(negedge clk);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_xfer_seq.md
BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 The block SHALL have parameter NREG, default 4: number of general purpose registers on the shared 8-bit bus (2 to 8).
REQ-002 The block SHALL have parameter SETTLE, default 1: bus-settle cycles with source drive asserted before the write strobe (0 to 15).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port clr  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  1  transfer request present.
REQ-006 Port req_ready  output  1  block can accept a request this cycle.
REQ-007 Port req_imm  input  1  1 = immediate load of req_data into the destination; 0 = register-to-register move.
REQ-008 Port req_src  input  3  source register index; ignored when req_imm=1.
REQ-009 Port req_dst  input  3  destination register index.
REQ-010 Port req_data  input  8  immediate value.
REQ-011 Port bus_in  input  8  sampled value of the shared bus.
REQ-012 Port bus_out  output  8  immediate value the sequencer drives onto the bus.
REQ-013 Port bus_oe  output  1  sequencer bus-drive enable.
REQ-014 Port oa  output  NREG  one-hot register output enables; bit i drives register i onto the bus.
REQ-015 Port wa  output  NREG  one-hot register write enables; bit i loads register i from the bus.
REQ-016 Port done  output  1  one-cycle pulse when a transfer completes.
REQ-017 Port err  output  1  one-cycle pulse when a request is rejected.
REQ-018 Port xfer_data  output  8  bus value captured by the last completed transfer.
REQ-019 Port xfer_count  output  8  number of completed transfers, modulo 256.

Function
REQ-020 The FSM SHALL have states IDLE, DRIVE, LATCH, DONE and ERR.
REQ-021 req_ready SHALL equal (state==IDLE) and not clr; a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-022 On acceptance, the block SHALL register req_imm, req_src, req_dst and req_data; later changes on the request inputs SHALL have no effect until the next acceptance.
REQ-023 Rejection: a request with req_dst>=NREG, or with req_imm=0 and (req_src>=NREG or req_src==req_dst), SHALL move the FSM to ERR.
REQ-024 ERR SHALL assert err for 1 cycle, assert no oa, wa or bus_oe bit, and return to IDLE.
REQ-025 A valid request SHALL move the FSM to DRIVE when SETTLE>0, otherwise directly to LATCH.
REQ-026 DRIVE SHALL last exactly SETTLE cycles, using an internal 4-bit down-counter, then move to LATCH.
REQ-027 In DRIVE and LATCH, the block SHALL assert oa[src] (move) or bus_oe with bus_out=req_data (immediate).
REQ-028 LATCH SHALL last 1 cycle and additionally assert wa[dst].
REQ-029 At the LATCH-ending edge, the block SHALL load xfer_data from bus_in, increment xfer_count with wrap 255->0, and move to DONE.
REQ-030 DONE SHALL assert done for 1 cycle and then return to IDLE.
REQ-031 Latency: done SHALL be high in the cycle exactly SETTLE+2 cycles after the accepting edge.
REQ-032 Throughput: back-to-back transfers SHALL occupy SETTLE+3 cycles each.
REQ-033 At most one bit of oa SHALL be high in any cycle, and never while bus_oe is high.
REQ-034 At most one bit of wa SHALL be high in any cycle; wa SHALL be high only in LATCH.
REQ-035 bus_out SHALL be 8'h00 whenever bus_oe=0.
REQ-036 oa, wa and bus_oe SHALL be combinationally forced to 0 in any cycle where clr=1, so no register write occurs in the reset cycle.

Reset
REQ-037 On a rising edge with clr=1, the block SHALL set state to IDLE, the settle counter to 0, xfer_data to 8'h00 and xfer_count to 8'h00.
REQ-038 From the cycle after that edge, the block SHALL hold done=0, err=0, oa=0, wa=0, bus_oe=0 and bus_out=8'h00; req_ready SHALL be 1 once clr falls.
REQ-039 clr SHALL take precedence over acceptance and over every state transition, including mid-transfer; an aborted transfer SHALL not assert done and SHALL not increment xfer_count.

Verification
REQ-040 Immediate load, SETTLE=1: req_imm=1, dst=2, data=8'hA5 accepted at edge 0 -> bus_oe and bus_out=8'hA5 high for 2 cycles, wa=4'b0100 in the second, done in cycle 3, xfer_data=8'hA5, xfer_count=1.
REQ-041 Move, SETTLE=0: src=1, dst=3, bus_in=8'h3C -> oa=4'b0010 for 1 cycle with wa=4'b1000 in the same cycle, done in the next cycle, xfer_data=8'h3C.
REQ-042 Rejects: src=dst=2 (move), then dst=5 with NREG=4 -> err pulse for each, oa=wa=bus_oe=0 throughout, xfer_count unchanged.
REQ-043 clr asserted during LATCH -> wa=0 in that cycle, no done, state IDLE, xfer_count=0, req_ready=1 after clr drops.
REQ-044 256 consecutive immediate transfers with req_valid held high -> xfer_count wraps to 8'h00, every transfer spaced SETTLE+3 cycles, one-hot checks never violated.
